// File: rtl/fifo_burst_req_ctrl.sv
// fifo_burst_req_ctrl: burst-request generator for one VDMA FIFO-to-AXI channel.
// Watches the FIFO fill level and a latched frame-tail flag and issues
// full-length or tail-length requests through a req/resp/done handshake.
// Optional idle-timeout flush is built when FIFO_REQ_TIMEOUT_EN is defined.
module fifo_burst_req_ctrl #(
   parameter int unsigned CNT_W   = 9,
   parameter int unsigned LSIZE   = 9,
   parameter int unsigned MAX_LEN = 256,
   parameter int unsigned TIMEOUT = 1024,
   parameter int unsigned TO_W    = 16
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic             enable,
   input  logic [LSIZE-1:0] cfg_len,
   input  logic [CNT_W-1:0] count,
   input  logic             tail,
   input  logic             fifo_empty,
   output logic             burst_req,
   output logic             tail_req,
   output logic [LSIZE-1:0] req_len,
   input  logic             resp,
   input  logic             done,
   output logic             busy,
   output logic             tail_flushed
);

   localparam int unsigned      CMP_W     = (CNT_W > LSIZE) ? CNT_W : LSIZE;
   localparam logic [LSIZE-1:0] MAX_LEN_L = LSIZE'(MAX_LEN);

   typedef enum logic [2:0] {
      IDLE,
      REQ_BURST,
      REQ_TAIL,
      WAIT_DONE,
      FSH
   } state_t;

   state_t           state_q, state_d;
   logic             burst_req_q, burst_req_d;
   logic             tail_req_q, tail_req_d;
   logic [LSIZE-1:0] req_len_q, req_len_d;
   logic             busy_q, busy_d;
   logic             tail_flushed_q, tail_flushed_d;
   logic             tail_pend_q, tail_pend_d;
   logic             is_tail_q, is_tail_d;

   logic [LSIZE-1:0] len_eff;
   logic             burst_cond;
   logic             req_ok;
   logic             to_fire;

   // Effective burst length: zero or oversize configuration clamps to MAX_LEN.
   always_comb begin
      len_eff = cfg_len;
      if (cfg_len == '0 || cfg_len > MAX_LEN_L) begin
         len_eff = MAX_LEN_L;
      end
   end

   // Arithmetic request conditions, compared at the wider of the two widths.
   always_comb begin
      burst_cond = (CMP_W'(count) >= CMP_W'(len_eff));
      req_ok     = enable && !fifo_empty;
   end

   // Timeout parameters only matter when the flush counter is built.
   if (TIMEOUT == 0 || TO_W == 0) begin : g_timeout_cfg_unused
   end

`ifdef FIFO_REQ_TIMEOUT_EN
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;

   // Idle timeout: count stranded-data cycles, fire and clear on reaching TIMEOUT.
   always_comb begin
      to_cnt_d = '0;
      to_fire  = 1'b0;
      if (state_q == IDLE && enable && count != '0 && !burst_cond && !tail_pend_q) begin
         if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
            to_fire = 1'b1;
         end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
         end
      end
   end

   // Timeout counter register.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt_q <= '0;
      end else begin
         to_cnt_q <= to_cnt_d;
      end
   end
`else
   // No counter: data below len_eff waits for a tail indication.
   always_comb begin
      to_fire = 1'b0;
   end
`endif

   // Next-state and next-output logic; every output is registered from here.
   always_comb begin
      state_d        = state_q;
      burst_req_d    = burst_req_q;
      tail_req_d     = tail_req_q;
      req_len_d      = req_len_q;
      is_tail_d      = is_tail_q;
      tail_flushed_d = 1'b0;
      tail_pend_d    = tail_pend_q | tail;

      case (state_q)
         IDLE: begin
            if (req_ok && burst_cond) begin
               state_d     = REQ_BURST;
               burst_req_d = 1'b1;
               req_len_d   = len_eff;
               is_tail_d   = 1'b0;
            end else if ((req_ok && tail_pend_q) || to_fire) begin
               state_d    = REQ_TAIL;
               tail_req_d = 1'b1;
               req_len_d  = LSIZE'(count);
               is_tail_d  = 1'b1;
            end
         end
         REQ_BURST, REQ_TAIL: begin
            if (resp) begin
               burst_req_d = 1'b0;
               tail_req_d  = 1'b0;
               req_len_d   = '0;
               if (done) begin
                  state_d        = FSH;
                  tail_flushed_d = is_tail_q && tail_pend_q;
               end else begin
                  state_d = WAIT_DONE;
               end
            end
         end
         WAIT_DONE: begin
            if (done) begin
               state_d        = FSH;
               tail_flushed_d = is_tail_q && tail_pend_q;
            end
         end
         FSH: begin
            state_d   = IDLE;
            is_tail_d = 1'b0;
            // The flush pulse marks the drained tail; a new tail this cycle wins.
            if (tail_flushed_q) begin
               tail_pend_d = tail;
            end
         end
         default: begin
            state_d     = IDLE;
            burst_req_d = 1'b0;
            tail_req_d  = 1'b0;
            req_len_d   = '0;
            is_tail_d   = 1'b0;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and registered outputs.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         burst_req_q    <= 1'b0;
         tail_req_q     <= 1'b0;
         req_len_q      <= '0;
         busy_q         <= 1'b0;
         tail_flushed_q <= 1'b0;
         tail_pend_q    <= 1'b0;
         is_tail_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         burst_req_q    <= burst_req_d;
         tail_req_q     <= tail_req_d;
         req_len_q      <= req_len_d;
         busy_q         <= busy_d;
         tail_flushed_q <= tail_flushed_d;
         tail_pend_q    <= tail_pend_d;
         is_tail_q      <= is_tail_d;
      end
   end

   // Output drive.
   always_comb begin
      burst_req    = burst_req_q;
      tail_req     = tail_req_q;
      req_len      = req_len_q;
      busy         = busy_q;
      tail_flushed = tail_flushed_q;
   end

endmodule

// File: tb/tb_fifo_burst_req_ctrl.sv
// Testbench for fifo_burst_req_ctrl: scoreboard of expected requests and
// flush pulses, fed by a transaction-level reference model.
module tb_fifo_burst_req_ctrl;

   localparam int CNT_W   = 9;
   localparam int LSIZE   = 9;
   localparam int MAX_LEN = 256;
   localparam int TIMEOUT = 16;

   logic             clock = 1'b0;
   logic             rst_n = 1'b0;
   logic             enable = 1'b0;
   logic [LSIZE-1:0] cfg_len = '0;
   logic [CNT_W-1:0] count = '0;
   logic             tail = 1'b0;
   logic             fifo_empty = 1'b1;
   logic             resp = 1'b0;
   logic             done = 1'b0;
   logic             burst_req, tail_req, busy, tail_flushed;
   logic [LSIZE-1:0] req_len;

   int total = 0;
   int bad   = 0;

   // kind: 0 = burst request, 1 = tail request, 2 = tail_flushed pulse
   typedef struct {
      int kind;
      int len;
   } ev_t;
   ev_t exp_q[$];

   int count_m     = 0;
   bit tail_pend_m = 1'b0;
   bit req_seen    = 1'b0;
   int held_len    = 0;

   always #5 clock = ~clock;

   fifo_burst_req_ctrl #(
      .CNT_W  (CNT_W),
      .LSIZE  (LSIZE),
      .MAX_LEN(MAX_LEN),
      .TIMEOUT(TIMEOUT),
      .TO_W   (16)
   ) dut (
      .clock       (clock),
      .rst_n       (rst_n),
      .enable      (enable),
      .cfg_len     (cfg_len),
      .count       (count),
      .tail        (tail),
      .fifo_empty  (fifo_empty),
      .burst_req   (burst_req),
      .tail_req    (tail_req),
      .req_len     (req_len),
      .resp        (resp),
      .done        (done),
      .busy        (busy),
      .tail_flushed(tail_flushed)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   task automatic push_ev(input int kind, input int len);
      ev_t e;
      e.kind = kind;
      e.len  = len;
      exp_q.push_back(e);
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a request or flush.
   always @(negedge clock) begin
      ev_t e;
      if (!rst_n) begin
         req_seen = 1'b0;
      end else begin
         if (burst_req || tail_req) begin
            check("req_exclusive", burst_req & tail_req, 0);
            if (!req_seen) begin
               req_seen = 1'b1;
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_req: got len %0d expected no request", req_len);
               end else begin
                  e = exp_q.pop_front();
                  check("req_kind", tail_req, e.kind);
                  check("req_len", req_len, e.len);
                  held_len = e.len;
               end
            end else begin
               check("req_len_hold", req_len, held_len);
            end
         end else begin
            req_seen = 1'b0;
            check("req_len_idle", req_len, 0);
         end
         if (tail_flushed) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_flush: got pulse expected none");
            end else begin
               e = exp_q.pop_front();
               check("flush_kind", e.kind, 2);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_count(input int c);
      count_m    = c;
      count      = CNT_W'(c);
      fifo_empty = (c == 0);
   endtask

   function automatic int len_eff_m(input int cfg);
      return (cfg == 0 || cfg > MAX_LEN) ? MAX_LEN : cfg;
   endfunction

   task automatic finish_test();
      check("exp_q_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   endtask

   task automatic wait_req(output int n, output bit got);
      got = 1'b0;
      n   = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clock);
         n++;
         if (burst_req || tail_req) got = 1'b1;
      end
   endtask

   // Master side of the handshake, starting at the negedge the request is seen.
   task automatic finish_req(input bit is_t, input int len, input bit sim, input int tmode);
      @(posedge clock);
      #1;
      if ($urandom_range(0, 1) == 1) enable = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
         done = 1'b1;
         tick();
         done = 1'b0;
      end
      repeat ($urandom_range(0, 2)) tick();
      if (tmode == 1) begin
         tail = 1'b1;
         tick();
         tail = 1'b0;
         if (!is_t) tail_pend_m = 1'b1;
      end
      check("req_held", burst_req | tail_req, 1);
      resp = 1'b1;
      done = sim;
      tick();
      resp = 1'b0;
      done = 1'b0;
      check("req_drop", burst_req | tail_req, 0);
      check("req_len_drop", req_len, 0);
      if (!sim) begin
         check("busy_wait", busy, 1);
         repeat ($urandom_range(0, 2)) begin
            resp = 1'b1;
            tick();
            resp = 1'b0;
         end
         done = 1'b1;
         tick();
         done = 1'b0;
      end
      check("busy_fsh", busy, 1);
      enable = 1'b0;
      set_count(count_m - len);
      if (is_t) tail_pend_m = 1'b0;
      if (tmode == 2) begin
         tail        = 1'b1;
         tail_pend_m = 1'b1;
      end
      tick();
      tail = 1'b0;
      check("busy_idle", busy, 0);
   endtask

   // One transaction: configure with requests disabled, predict, then enable.
   task automatic do_txn(input int cfg, input int cnt, input bit tail_in, input bit sim, input int tmode);
      int le, len, n;
      bit got, expect_req, is_t;
      enable  = 1'b0;
      cfg_len = LSIZE'(cfg);
      set_count(cnt);
      tail = tail_in;
      if (tail_in) tail_pend_m = 1'b1;
      resp = 1'($urandom_range(0, 1));
      tick();
      tail = 1'b0;
      resp = 1'b0;
      le         = len_eff_m(cfg);
      expect_req = 1'b1;
      is_t       = 1'b0;
      len        = 0;
      if (count_m == 0) expect_req = 1'b0;
      else if (count_m >= le) len = le;
      else if (tail_pend_m) begin
         len  = count_m;
         is_t = 1'b1;
      end else expect_req = 1'b0;
      if (expect_req) begin
         push_ev(is_t ? 1 : 0, len);
         if (is_t) push_ev(2, 0);
      end
      enable = 1'b1;
      if (!expect_req) begin
         repeat (4) @(negedge clock);
         check("idle_no_busy", busy, 0);
         @(posedge clock);
         #1;
         enable = 1'b0;
         return;
      end
      wait_req(n, got);
      check("req_arrived", got, 1);
      if (!got) finish_test();
      check("req_latency", n, 2);
      finish_req(is_t, len, sim, tmode);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running, expected finish");
      $fatal(1);
   end

   initial begin
      int n;
      bit got;
      int cfg, cnt;

      #12;
      check("rst_burst_req", burst_req, 0);
      check("rst_tail_req", tail_req, 0);
      check("rst_req_len", req_len, 0);
      check("rst_busy", busy, 0);
      check("rst_flushed", tail_flushed, 0);
      @(posedge clock);
      #1;
      rst_n = 1'b1;
      tick();

      // Count stepping up to the burst length.
      do_txn(128, 100, 0, 0, 0);
      do_txn(128, 128, 0, 0, 0);

      // Tail longer than one burst drains as two bursts plus a tail.
      do_txn(128, 300, 1, 0, 0);
      do_txn(128, count_m, 0, 0, 0);
      do_txn(128, count_m, 0, 0, 0);

      // Length clamp.
      do_txn(0, 256, 0, 0, 0);
      do_txn(500, 256, 0, 0, 0);

      // resp and done together.
      do_txn(128, 130, 0, 1, 0);
      do_txn(128, 60, 1, 1, 0);

      // Reset during WAIT_DONE.
      enable  = 1'b0;
      cfg_len = 9'd128;
      set_count(200);
      tail        = 1'b1;
      tail_pend_m = 1'b1;
      tick();
      tail = 1'b0;
      push_ev(0, 128);
      enable = 1'b1;
      wait_req(n, got);
      check("rst_test_req", got, 1);
      if (!got) finish_test();
      @(posedge clock);
      #1;
      resp = 1'b1;
      tick();
      resp = 1'b0;
      check("busy_before_rst", busy, 1);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_rst_req", burst_req | tail_req, 0);
      check("async_rst_len", req_len, 0);
      check("async_rst_busy", busy, 0);
      tail_pend_m = 1'b0;
      @(posedge clock);
      #1;
      push_ev(0, 128);
      rst_n = 1'b1;
      wait_req(n, got);
      check("post_rst_req", got, 1);
      if (!got) finish_test();
      check("post_rst_latency", n, 2);
      finish_req(0, 128, 0, 0);
      do_txn(128, count_m, 0, 0, 0);

      // Stranded data with no tail.
      enable  = 1'b0;
      cfg_len = 9'd128;
      set_count(5);
      tick();
`ifdef FIFO_REQ_TIMEOUT_EN
      push_ev(1, 5);
      enable = 1'b1;
      wait_req(n, got);
      check("timeout_req", got, 1);
      if (!got) finish_test();
      check("timeout_latency", n, TIMEOUT + 1);
      finish_req(1, 5, 0, 0);
`else
      enable = 1'b1;
      repeat (40) @(negedge clock);
      check("no_timeout_busy", busy, 0);
      @(posedge clock);
      #1;
      enable = 1'b0;
`endif

      // Randomized transactions.
      for (int i = 0; i < 80; i++) begin
         case ($urandom_range(0, 3))
            0:       cfg = 0;
            1:       cfg = $urandom_range(257, 511);
            default: cfg = $urandom_range(1, 256);
         endcase
         cnt = ($urandom_range(0, 2) == 0) ? count_m : $urandom_range(0, 511);
         do_txn(cfg, cnt, ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                $urandom_range(0, 2));
      end

      repeat (3) tick();
      finish_test();
   end

endmodule

// File: doc/fifo_burst_req_ctrl.md
# fifo_burst_req_ctrl

Burst-request generator for one VDMA FIFO-to-AXI channel. It watches the FIFO fill level and the frame-tail flag, then issues full-length or tail-length burst requests to the AXI master through a req/resp/done handshake. It generalises the fixed-threshold controller: count width, maximum length and burst length are configurable, tails longer than one burst drain correctly, and an optional idle timeout flushes stranded data.

## Interface
- CNT_W, 9, width of FIFO `count`
- LSIZE, 9, width of `cfg_len` and `req_len`
- MAX_LEN, 256, largest legal burst length in beats
- TIMEOUT, 1024, idle cycles before a timeout flush (used only with the macro)
- TO_W, 16, timeout counter width

- clock  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- enable  in  1  allows new requests from IDLE
- cfg_len  in  LSIZE  burst length in beats; 0 or >MAX_LEN clamps to MAX_LEN
- count  in  CNT_W  FIFO fill level in beats
- tail  in  1  end-of-frame pulse or level; latched
- fifo_empty  in  1  FIFO empty flag
- burst_req  out  1  full-length request
- tail_req  out  1  partial or tail request
- req_len  out  LSIZE  beats requested; valid while a request is high, otherwise 0
- resp  in  1  master accepted the request
- done  in  1  master finished the burst
- busy  out  1  state ≠ IDLE
- tail_flushed  out  1  one-cycle pulse when the latched tail is fully drained

## Operation
- States: IDLE, REQ_BURST, REQ_TAIL, WAIT_DONE, FSH.
- IDLE behaviour:
  - Requests are considered only if `enable` is high and `fifo_empty` is low.
  - `len_eff` = clamped `cfg_len`, sampled in IDLE only.
  - If `count` ≥ `len_eff`, go to REQ_BURST with `req_len` = `len_eff`.
  - Else if `tail_pend`, go to REQ_TAIL with `req_len` = `count`.
  - Burst has priority over tail.
- Tail latching:
  - `tail_pend` is set by `tail`=1 at any state.
  - While `tail_pend` is set and `count` ≥ `len_eff`, full bursts are issued first (tail drains in multiple bursts).
  - `tail_pend` clears in FSH when the completed request was REQ_TAIL. `tail_flushed` pulses in that same cycle.
  - A `tail` arriving in that same FSH cycle re-sets `tail_pend` (set wins).
- REQ_BURST / REQ_TAIL:
  - Hold the request and `req_len` until `resp`=1, then go to WAIT_DONE.
  - If `resp` and `done` are both 1 in the same cycle, go directly to FSH.
- WAIT_DONE: on `done`=1, go to FSH.
- FSH: one cycle that lets the FIFO count settle; then IDLE.
- Ignored inputs:
  - `resp` outside the REQ states.
  - `done` outside WAIT_DONE, except the simultaneous-with-`resp` case above.
- `enable` deassertion does not abort an in-flight request.
- Arithmetic:
  - Compare `count` against `len_eff` zero-extended to max(CNT_W, LSIZE).
  - `req_len` for a tail = `count` truncated to LSIZE; the tail path is only taken when `count` < `len_eff` ≤ MAX_LEN, so no overflow.

## Timing
- Reset: all outputs 0, state IDLE, `tail_pend` 0, timeout counter 0.
- Outputs are registered from next-state.
  - `burst_req`/`tail_req` rise 1 cycle after the IDLE edge where the condition holds.
  - They fall the cycle after `resp` is sampled high.
- Minimum request spacing: resp cycle, then done cycle, then FSH, then the IDLE evaluation edge; at least 1 idle cycle between requests.
- `busy` is high from the first REQ cycle through FSH.
- Reset mid-operation returns to IDLE immediately and drops all requests; the pending tail is lost.

## Configuration
- FIFO_REQ_TIMEOUT_EN defined:
  - A TO_W counter increments in IDLE while `enable`=1, `count`≠0 and neither the burst nor the tail condition holds.
  - The counter clears on any other condition.
  - On reaching TIMEOUT it forces REQ_TAIL with `req_len`=`count`, then clears.
  - `tail_pend` is unaffected, and no `tail_flushed` pulse is produced unless `tail_pend` was set.
- FIFO_REQ_TIMEOUT_EN not defined: no counter is built. Data below `len_eff` waits indefinitely for `tail`.

## Test plan
- `cfg_len`=128, `count` steps 100→128 → `burst_req`=1 with `req_len`=128 one cycle later; `resp` then `done` → FSH, then IDLE; `busy` falls.
- `count`=300, `cfg_len`=128, `tail` pulsed:
  - two bursts of 128, then `tail_req` with `req_len`=44 (count driven down by the bench);
  - `tail_flushed` pulses once, in the final FSH.
- `cfg_len`=0 and `cfg_len`=500 with `count`=256 → `req_len`=256 (MAX_LEN clamp) in both cases.
- `resp` and `done` high in the same cycle during REQ_BURST → FSH on the next edge; no hang in WAIT_DONE.
- `rst_n` asserted during WAIT_DONE → all outputs 0 asynchronously; a new burst is issued after release when `count` ≥ `len_eff`.
- With FIFO_REQ_TIMEOUT_EN, TIMEOUT=16, `count`=5 held → `tail_req` with `req_len`=5 after 16 IDLE cycles + 1; no `tail_flushed`. Without the macro → no request.
